// File: rtl/sc_state_endpoint.sv
// sc_state_endpoint: far end of the 32-bit state-channel AXI-Stream in a reconfigurable
// module. A save command snapshots the live state bank and streams it out on m_axis_sc.
// A load command receives a state frame on s_axis_sc and, if the frame is well formed,
// restores state_out atomically.
//
// Ports:
//   axis_aclk, axis_resetn     clock, asynchronous active-low reset
//   sc_save, sc_load, sc_port  commands, sampled in IDLE when sc_port == PORT_ID
//   s_axis_sc_*                load stream (sink)
//   m_axis_sc_*                save stream (source)
//   state_in                   live state bank, word i at [i*SC_WIDTH +: SC_WIDTH]
//   state_out                  restored state bank
//   state_load_valid           one-cycle pulse when state_out has been updated
//   busy                       high outside IDLE
//   error                      one-cycle pulse after a malformed load frame ends
module sc_state_endpoint #(
    parameter int unsigned SC_WIDTH    = 32,
    parameter int unsigned STATE_WORDS = 8,
    parameter logic [3:0]  PORT_ID     = 4'd0
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic                            sc_save,
    input  logic                            sc_load,
    input  logic [3:0]                      sc_port,
    input  logic [SC_WIDTH-1:0]             s_axis_sc_tdata,
    input  logic [SC_WIDTH/8-1:0]           s_axis_sc_tkeep,
    input  logic                            s_axis_sc_tvalid,
    output logic                            s_axis_sc_tready,
    input  logic                            s_axis_sc_tlast,
    output logic [SC_WIDTH-1:0]             m_axis_sc_tdata,
    output logic [SC_WIDTH/8-1:0]           m_axis_sc_tkeep,
    output logic                            m_axis_sc_tvalid,
    input  logic                            m_axis_sc_tready,
    output logic                            m_axis_sc_tlast,
    input  logic [STATE_WORDS*SC_WIDTH-1:0] state_in,
    output logic [STATE_WORDS*SC_WIDTH-1:0] state_out,
    output logic                            state_load_valid,
    output logic                            busy,
    output logic                            error
);

    localparam int unsigned     KeepW    = SC_WIDTH / 8;
    localparam int unsigned     CntW     = $clog2(STATE_WORDS);
    localparam logic [CntW-1:0] CntLast  = CntW'(STATE_WORDS - 1);
    localparam logic [KeepW-1:0] KeepOnes = {KeepW{1'b1}};

    typedef enum logic [1:0] {StIdle, StSave, StLoad, StDrain} state_e;

    state_e                          state_q;
    logic [CntW-1:0]                 cnt_q;
    logic [SC_WIDTH-1:0]             shadow_q [STATE_WORDS];
    logic [SC_WIDTH-1:0]             m_tdata_q;
    logic [KeepW-1:0]                m_tkeep_q;
    logic                            m_tvalid_q;
    logic                            m_tlast_q;
    logic                            s_tready_q;
    logic [STATE_WORDS*SC_WIDTH-1:0] state_out_q;
    logic                            state_load_valid_q;
    logic                            busy_q;
    logic                            error_q;

    logic [CntW-1:0]                 cnt_nxt;
    logic                            cmd_hit;
    logic                            s_hs;
    logic                            m_hs;
    logic                            keep_ok;
    logic                            at_last;
    logic [STATE_WORDS*SC_WIDTH-1:0] load_bank;

    always_comb begin
        cnt_nxt = cnt_q + CntW'(1);
        cmd_hit = (sc_port == PORT_ID);
        s_hs    = s_axis_sc_tvalid && s_tready_q;
        m_hs    = m_tvalid_q && m_axis_sc_tready;
        keep_ok = (s_axis_sc_tkeep == KeepOnes);
        at_last = (cnt_q == CntLast);
        // Shadow bank as it will look once the current beat is written, so a good frame
        // can be committed to state_out on the same edge that accepts its last beat.
        load_bank = '0;
        for (int unsigned i = 0; i < STATE_WORDS; i++) begin
            load_bank[i*SC_WIDTH +: SC_WIDTH] =
                (CntW'(i) == cnt_q) ? s_axis_sc_tdata : shadow_q[i];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q            <= StIdle;
            cnt_q              <= '0;
            m_tdata_q          <= '0;
            m_tkeep_q          <= '0;
            m_tvalid_q         <= 1'b0;
            m_tlast_q          <= 1'b0;
            s_tready_q         <= 1'b0;
            state_out_q        <= '0;
            state_load_valid_q <= 1'b0;
            busy_q             <= 1'b0;
            error_q            <= 1'b0;
            for (int unsigned i = 0; i < STATE_WORDS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            error_q            <= 1'b0;
            state_load_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Save wins over a simultaneous load; the load is dropped.
                    if (cmd_hit && sc_save) begin
                        for (int unsigned i = 0; i < STATE_WORDS; i++) begin
                            shadow_q[i] <= state_in[i*SC_WIDTH +: SC_WIDTH];
                        end
                        m_tdata_q  <= state_in[SC_WIDTH-1:0];
                        m_tkeep_q  <= KeepOnes;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;  // at least two words, so word 0 is never last
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StSave;
                    end else if (cmd_hit && sc_load) begin
                        s_tready_q <= 1'b1;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StSave: begin
                    if (m_hs) begin
                        if (at_last) begin
                            m_tdata_q  <= '0;
                            m_tkeep_q  <= '0;
                            m_tvalid_q <= 1'b0;
                            m_tlast_q  <= 1'b0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            cnt_q     <= cnt_nxt;
                            m_tdata_q <= shadow_q[cnt_nxt];
                            m_tlast_q <= (cnt_nxt == CntLast);
                        end
                    end
                end
                StLoad: begin
                    if (s_hs) begin
                        shadow_q[cnt_q] <= s_axis_sc_tdata;
                        if (s_axis_sc_tlast) begin
                            s_tready_q <= 1'b0;
                            cnt_q      <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= StIdle;
                            if (at_last && keep_ok) begin
                                state_out_q        <= load_bank;
                                state_load_valid_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                        end else if (!keep_ok || at_last) begin
                            // Overlong frame or bad byte enables: swallow the rest.
                            cnt_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                StDrain: begin
                    if (s_hs && s_axis_sc_tlast) begin
                        s_tready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis_sc_tdata  = m_tdata_q;
    assign m_axis_sc_tkeep  = m_tkeep_q;
    assign m_axis_sc_tvalid = m_tvalid_q;
    assign m_axis_sc_tlast  = m_tlast_q;
    assign s_axis_sc_tready = s_tready_q;
    assign state_out        = state_out_q;
    assign state_load_valid = state_load_valid_q;
    assign busy             = busy_q;
    assign error            = error_q;

endmodule

// File: tb/tb_sc_state_endpoint.sv
// Self-checking bench for sc_state_endpoint (STATE_WORDS=8, PORT_ID=2). Expected values come
// from a frame-level model: a load frame is good iff it has exactly STATE_WORDS beats up to
// its tlast and every beat has all byte enables set; any other frame yields one error pulse.
module tb_sc_state_endpoint;

    localparam int         W    = 8;
    localparam int         DW   = 32;
    localparam logic [3:0] PORT = 4'd2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              sc_save = 1'b0;
    logic              sc_load = 1'b0;
    logic [3:0]        sc_port = 4'd0;
    logic [DW-1:0]     s_tdata = '0;
    logic [DW/8-1:0]   s_tkeep = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    logic [DW-1:0]     m_tdata;
    logic [DW/8-1:0]   m_tkeep;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic              m_tlast;
    logic [W*DW-1:0]   state_in = '0;
    logic [W*DW-1:0]   state_out;
    logic              slv;
    logic              busy;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;
    int slv_pulses = 0;

    logic [W*DW-1:0] exp_out = '0;
    logic [DW-1:0]   fdata [16];
    logic [3:0]      fkeep [16];

    sc_state_endpoint #(
        .SC_WIDTH   (DW),
        .STATE_WORDS(W),
        .PORT_ID    (PORT)
    ) dut (
        .axis_aclk       (clk),
        .axis_resetn     (resetn),
        .sc_save         (sc_save),
        .sc_load         (sc_load),
        .sc_port         (sc_port),
        .s_axis_sc_tdata (s_tdata),
        .s_axis_sc_tkeep (s_tkeep),
        .s_axis_sc_tvalid(s_tvalid),
        .s_axis_sc_tready(s_tready),
        .s_axis_sc_tlast (s_tlast),
        .m_axis_sc_tdata (m_tdata),
        .m_axis_sc_tkeep (m_tkeep),
        .m_axis_sc_tvalid(m_tvalid),
        .m_axis_sc_tready(m_tready),
        .m_axis_sc_tlast (m_tlast),
        .state_in        (state_in),
        .state_out       (state_out),
        .state_load_valid(slv),
        .busy            (busy),
        .error           (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (error) err_pulses++;
        if (slv)   slv_pulses++;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_state_out"}, state_out, '0);
        check_eq({tag, "_tready"}, s_tready, 0);
        check_eq({tag, "_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_tdata"}, m_tdata, 0);
        check_eq({tag, "_tkeep"}, m_tkeep, 0);
        check_eq({tag, "_tlast"}, m_tlast, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_error"}, error, 0);
        check_eq({tag, "_slv"}, slv, 0);
    endtask

    task automatic set_state_in_seq(input logic [DW-1:0] base);
        for (int i = 0; i < W; i++) state_in[i*DW +: DW] = base + DW'(i);
    endtask

    task automatic set_state_in_rand();
        for (int i = 0; i < W; i++) state_in[i*DW +: DW] = $urandom;
    endtask

    // mode 0: always ready, 1: ready toggles every cycle, 2: random ready
    task automatic do_save(input int mode, input bit also_load);
        logic [DW-1:0] snap [W];
        logic [DW-1:0] prev_data;
        bit            prev_stall;
        bit            rdy;
        int            k;
        int            cyc;
        for (int i = 0; i < W; i++) snap[i] = state_in[i*DW +: DW];
        sc_save = 1'b1;
        sc_load = also_load;
        sc_port = PORT;
        tick();
        sc_save = 1'b0;
        sc_load = 1'b0;
        check_eq("save_valid_start", m_tvalid, 1);
        check_eq("save_busy", busy, 1);
        check_eq("save_no_load_ready", s_tready, 0);
        k = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        while (k < W && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            m_tready = rdy;
            if (prev_stall) check_eq("save_hold", m_tdata, prev_data);
            if (m_tvalid && rdy) begin
                check_eq("save_data", m_tdata, snap[k]);
                check_eq("save_last", m_tlast, (k == W - 1));
                check_eq("save_keep", m_tkeep, 4'hF);
                k++;
            end
            prev_stall = m_tvalid && !rdy;
            prev_data  = m_tdata;
            if (cyc == 3) set_state_in_rand();
            tick();
            cyc++;
        end
        m_tready = 1'b0;
        check_eq("save_beats", k, W);
        check_eq("save_done_busy", busy, 0);
        check_eq("save_done_valid", m_tvalid, 0);
    endtask

    task automatic send_frame(input int len, output bit timeout);
        int  k;
        int  budget;
        bit  hs;
        k = 0;
        budget = 0;
        timeout = 1'b0;
        while (k < len) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = fdata[k];
            s_tkeep  = fkeep[k];
            s_tlast  = (k == len - 1);
            hs = s_tvalid && s_tready;
            tick();
            if (hs) k++;
            budget++;
            if (budget > 300) begin
                timeout = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic do_load(input int len);
        bit good;
        bit to;
        int e0;
        int v0;
        good = (len == W);
        for (int k = 0; k < len; k++) if (fkeep[k] != 4'hF) good = 1'b0;
        e0 = err_pulses;
        v0 = slv_pulses;
        sc_load = 1'b1;
        sc_port = PORT;
        tick();
        sc_load = 1'b0;
        check_eq("load_ready", s_tready, 1);
        check_eq("load_busy", busy, 1);
        send_frame(len, to);
        check_eq("load_timeout", to, 0);
        check_eq("load_error", error, !good);
        check_eq("load_valid", slv, good);
        if (good) for (int k = 0; k < W; k++) exp_out[k*DW +: DW] = fdata[k];
        check_eq("load_state_out", state_out, exp_out);
        tick();
        check_eq("load_error_gone", error, 0);
        check_eq("load_valid_gone", slv, 0);
        check_eq("load_idle_busy", busy, 0);
        check_eq("load_idle_ready", s_tready, 0);
        check_eq("load_error_count", err_pulses - e0, !good);
        check_eq("load_valid_count", slv_pulses - v0, good);
    endtask

    task automatic fill_frame(input int len, input logic [DW-1:0] base, input bit rnd);
        for (int k = 0; k < 16; k++) begin
            fdata[k] = rnd ? $urandom : base + DW'(k);
            fkeep[k] = 4'hF;
        end
        if (len < 0) fkeep[0] = 4'hF;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_all_zero("rst");
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_all_zero("post_rst");

        // Directed save, always ready
        set_state_in_seq(32'hA0);
        do_save(0, 1'b0);

        // Save with toggling ready and state_in changing mid-stream
        set_state_in_seq(32'hA0);
        do_save(1, 1'b0);

        // Good load 0x10..0x17
        fill_frame(W, 32'h10, 1'b0);
        do_load(W);
        check_eq("good_load_value", state_out,
                 {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10});

        // Early tlast, then a good load
        fill_frame(5, 32'h20, 1'b0);
        do_load(5);
        fill_frame(W, 32'h30, 1'b1);
        do_load(W);

        // Overlong frame goes through drain
        fill_frame(10, 32'h40, 1'b0);
        do_load(10);

        // Bad byte enables on a middle beat and on the last beat
        fill_frame(W, 32'h50, 1'b0);
        fkeep[3] = 4'h7;
        do_load(W);
        fill_frame(W, 32'h60, 1'b0);
        fkeep[W-1] = 4'hE;
        do_load(W);

        // Save and load together: save wins
        set_state_in_rand();
        do_save(2, 1'b1);

        // Command to another port: no activity
        sc_save = 1'b1;
        sc_load = 1'b1;
        sc_port = 4'd3;
        tick();
        sc_save = 1'b0;
        sc_load = 1'b0;
        check_eq("other_port_busy", busy, 0);
        check_eq("other_port_valid", m_tvalid, 0);
        check_eq("other_port_ready", s_tready, 0);

        // Randomized mix of saves and loads
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_state_in_rand();
                do_save(2, 1'b0);
            end else begin
                int len;
                len = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(1, 11));
                fill_frame(len, '0, 1'b1);
                if ($urandom_range(0, 4) == 0) fkeep[$urandom_range(0, len - 1)] = 4'h3;
                do_load(len);
            end
        end

        // Make sure state_out holds something before the reset test
        fill_frame(W, 32'h70, 1'b0);
        do_load(W);

        // Reset during beat 3 of a load
        sc_load = 1'b1;
        sc_port = PORT;
        tick();
        sc_load  = 1'b0;
        s_tvalid = 1'b1;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b0;
        s_tdata  = 32'h55;
        repeat (2) tick();
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("mid_rst");
        s_tvalid = 1'b0;
        exp_out = '0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_all_zero("mid_rst_release");

        // Recovery after reset
        fill_frame(W, 32'h80, 1'b1);
        do_load(W);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
